// File: rtl/bb_hakem_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the BRAM.
// Members:
//   fetch  : gt_istek_g, gt_adres_g, gt_iptal_g -> gt_hazir_c, gt_yanit_{gecerli,veri,hata}_c
//   loader : yk_istek_g, yk_yaz_g, yk_kilit_g, yk_adres_g, yk_veri_g, yk_maske_g
//            -> yk_hazir_c, yk_yanit_{gecerli,veri,hata}_c
//   BRAM   : bb_addra_c, bb_ena_c, bb_wea_c, bb_dina_c <- bb_douta_g
// slave modport is the arbiter side, master is the requester/memory side.
interface bb_hakem_if #(
  parameter int unsigned ADRES_BIT     = 32,
  parameter int unsigned BB_SOZCUK_BIT = 12
);
  logic                     gt_istek_g;
  logic [ADRES_BIT-1:0]     gt_adres_g;
  logic                     gt_hazir_c;
  logic                     gt_iptal_g;
  logic                     gt_yanit_gecerli_c;
  logic [31:0]              gt_yanit_veri_c;
  logic                     gt_yanit_hata_c;

  logic                     yk_istek_g;
  logic                     yk_yaz_g;
  logic                     yk_kilit_g;
  logic [ADRES_BIT-1:0]     yk_adres_g;
  logic [31:0]              yk_veri_g;
  logic [3:0]               yk_maske_g;
  logic                     yk_hazir_c;
  logic                     yk_yanit_gecerli_c;
  logic [31:0]              yk_yanit_veri_c;
  logic                     yk_yanit_hata_c;

  logic [BB_SOZCUK_BIT-1:0] bb_addra_c;
  logic                     bb_ena_c;
  logic [3:0]               bb_wea_c;
  logic [31:0]              bb_dina_c;
  logic [31:0]              bb_douta_g;

  modport slave (
    input  gt_istek_g, gt_adres_g, gt_iptal_g,
    output gt_hazir_c, gt_yanit_gecerli_c, gt_yanit_veri_c, gt_yanit_hata_c,
    input  yk_istek_g, yk_yaz_g, yk_kilit_g, yk_adres_g, yk_veri_g, yk_maske_g,
    output yk_hazir_c, yk_yanit_gecerli_c, yk_yanit_veri_c, yk_yanit_hata_c,
    output bb_addra_c, bb_ena_c, bb_wea_c, bb_dina_c,
    input  bb_douta_g
  );

  modport master (
    output gt_istek_g, gt_adres_g, gt_iptal_g,
    input  gt_hazir_c, gt_yanit_gecerli_c, gt_yanit_veri_c, gt_yanit_hata_c,
    output yk_istek_g, yk_yaz_g, yk_kilit_g, yk_adres_g, yk_veri_g, yk_maske_g,
    input  yk_hazir_c, yk_yanit_gecerli_c, yk_yanit_veri_c, yk_yanit_hata_c,
    input  bb_addra_c, bb_ena_c, bb_wea_c, bb_dina_c,
    output bb_douta_g
  );
endinterface

// File: rtl/bb_hakem.sv
// Arbiter for the single instruction-memory BRAM port shared by the fetch front end
// (read-only) and the program loader (read/write). Checks address range/alignment,
// arbitrates round-robin with an optional loader lock bounded by KILIT_SINIR, and
// routes the 1-cycle BRAM response back to the owner.
// Ports:
//   clk_g  : clock, all state on the rising edge
//   rst_g  : synchronous active-high reset
//   bus    : bb_hakem_if.slave (fetch, loader and BRAM signals)
module bb_hakem #(
  parameter int unsigned          ADRES_BIT     = 32,
  parameter logic [ADRES_BIT-1:0] BB_TABAN_ADR  = ADRES_BIT'(32'h0000_1000),
  parameter int unsigned          BB_SOZCUK_BIT = 12,
  parameter int unsigned          KILIT_SINIR   = 64
) (
  input  logic       clk_g,
  input  logic       rst_g,
  bb_hakem_if.slave  bus
);

  localparam int unsigned          SAYAC_BIT = $clog2(KILIT_SINIR + 1);
  localparam logic [ADRES_BIT-1:0] BB_BOYUT  = ADRES_BIT'(64'(4) << BB_SOZCUK_BIT);
  localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(KILIT_SINIR);

  typedef enum logic {SERBEST = 1'b0, KILITLI = 1'b1} durum_t;

  // Offset is taken at full address width so addresses below base cannot alias.
  function automatic logic adres_gecerli(input logic [ADRES_BIT-1:0] a);
    logic [ADRES_BIT-1:0] ofs;
    ofs = a - BB_TABAN_ADR;
    return (a[1:0] == 2'b00) && (a >= BB_TABAN_ADR) && (ofs < BB_BOYUT);
  endfunction

  function automatic logic [BB_SOZCUK_BIT-1:0] kelime_adres(input logic [ADRES_BIT-1:0] a);
    return BB_SOZCUK_BIT'((a - BB_TABAN_ADR) >> 2);
  endfunction

  durum_t               r_durum, w_durum_sonraki;
  logic [SAYAC_BIT-1:0] r_sayac, w_sayac_sonraki;
  logic                 r_son_yk, w_son_yk_sonraki;        // last grant went to loader
  logic                 r_gt_oncelik, w_gt_oncelik_sonraki; // fetch wins next SERBEST cycle
  logic                 w_gt_kabul, w_yk_kabul;

  logic                 r_yanit_gecerli, r_yanit_yk, r_yanit_hata, r_yanit_yaz;

  logic                 w_gt_yasal, w_yk_yasal, w_erisim, w_yazma;
  logic [ADRES_BIT-1:0] w_sec_adres;
  logic [31:0]          w_yanit_veri;
  logic                 w_gt_yanit, w_yk_yanit;

  // Arbitration and lock state machine; nothing is granted while reset is asserted.
  always_comb begin
    w_durum_sonraki      = r_durum;
    w_sayac_sonraki      = r_sayac;
    w_son_yk_sonraki     = r_son_yk;
    w_gt_oncelik_sonraki = r_gt_oncelik;
    w_gt_kabul           = 1'b0;
    w_yk_kabul           = 1'b0;
    if (!rst_g) begin
      case (r_durum)
        SERBEST: begin
          w_gt_oncelik_sonraki = 1'b0;
          if (bus.gt_istek_g && bus.yk_istek_g) begin
            if (r_gt_oncelik || r_son_yk) w_gt_kabul = 1'b1;
            else                          w_yk_kabul = 1'b1;
          end else if (bus.gt_istek_g) begin
            w_gt_kabul = 1'b1;
          end else if (bus.yk_istek_g) begin
            w_yk_kabul = 1'b1;
          end
          if (w_yk_kabul && bus.yk_kilit_g) begin
            w_durum_sonraki = KILITLI;
            w_sayac_sonraki = '0;
          end
        end
        KILITLI: begin
          w_yk_kabul = bus.yk_istek_g;
          if (w_yk_kabul && bus.gt_istek_g) w_sayac_sonraki = r_sayac + SAYAC_BIT'(1);
          // Lock release and starvation limit merge into one return to SERBEST.
          if (!bus.yk_kilit_g || (w_sayac_sonraki == SAYAC_SON)) w_durum_sonraki = SERBEST;
          if (w_sayac_sonraki == SAYAC_SON) w_gt_oncelik_sonraki = 1'b1;
        end
        default: w_durum_sonraki = SERBEST;
      endcase
      if (w_gt_kabul) w_son_yk_sonraki = 1'b0;
      if (w_yk_kabul) w_son_yk_sonraki = 1'b1;
    end
  end

  // Arbiter state and the response pipeline stage.
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      r_durum         <= SERBEST;
      r_sayac         <= '0;
      r_son_yk        <= 1'b1;
      r_gt_oncelik    <= 1'b0;
      r_yanit_gecerli <= 1'b0;
      r_yanit_yk      <= 1'b0;
      r_yanit_hata    <= 1'b0;
      r_yanit_yaz     <= 1'b0;
    end else begin
      r_durum         <= w_durum_sonraki;
      r_sayac         <= w_sayac_sonraki;
      r_son_yk        <= w_son_yk_sonraki;
      r_gt_oncelik    <= w_gt_oncelik_sonraki;
      r_yanit_gecerli <= w_gt_kabul | w_yk_kabul;
      r_yanit_yk      <= w_yk_kabul;
      r_yanit_hata    <= w_yk_kabul ? ~w_yk_yasal : ~w_gt_yasal;
      r_yanit_yaz     <= w_yazma;
    end
  end

  // BRAM request path: only a granted legal access enables the port.
  always_comb begin
    w_gt_yasal  = adres_gecerli(bus.gt_adres_g);
    w_yk_yasal  = adres_gecerli(bus.yk_adres_g);
    w_sec_adres = w_yk_kabul ? bus.yk_adres_g : bus.gt_adres_g;
    w_erisim    = (w_gt_kabul & w_gt_yasal) | (w_yk_kabul & w_yk_yasal);
    w_yazma     = w_yk_kabul & bus.yk_yaz_g;
  end

  assign bus.gt_hazir_c = w_gt_kabul;
  assign bus.yk_hazir_c = w_yk_kabul;
  assign bus.bb_ena_c   = w_erisim;
  assign bus.bb_addra_c = w_erisim ? kelime_adres(w_sec_adres) : '0;
  assign bus.bb_wea_c   = (w_erisim && w_yazma) ? bus.yk_maske_g : 4'b0000;
  assign bus.bb_dina_c  = (w_erisim && w_yazma) ? bus.yk_veri_g  : 32'h0;

  // Response path: read data only for legal reads; writes and errors return zero.
  always_comb begin
    w_yanit_veri = (r_yanit_gecerli && !r_yanit_hata && !r_yanit_yaz) ? bus.bb_douta_g : 32'h0;
    w_gt_yanit   = r_yanit_gecerli & ~r_yanit_yk & ~bus.gt_iptal_g & ~rst_g;
    w_yk_yanit   = r_yanit_gecerli &  r_yanit_yk & ~rst_g;
  end

  assign bus.gt_yanit_gecerli_c = w_gt_yanit;
  assign bus.gt_yanit_veri_c    = w_gt_yanit ? w_yanit_veri : 32'h0;
  assign bus.gt_yanit_hata_c    = w_gt_yanit & r_yanit_hata;
  assign bus.yk_yanit_gecerli_c = w_yk_yanit;
  assign bus.yk_yanit_veri_c    = w_yk_yanit ? w_yanit_veri : 32'h0;
  assign bus.yk_yanit_hata_c    = w_yk_yanit & r_yanit_hata;

endmodule

// File: tb/tb_bb_hakem.sv
// Testbench for bb_hakem: drives fetch/loader requests, models the BRAM, and
// compares responses against a scoreboard of expectations queued at grant time.
module tb_bb_hakem;

  logic clk_g = 1'b0;
  logic rst_g;
  always #5 clk_g = ~clk_g;

  bb_hakem_if #(.ADRES_BIT(32), .BB_SOZCUK_BIT(12)) bus ();

  bb_hakem dut (
    .clk_g (clk_g),
    .rst_g (rst_g),
    .bus   (bus.slave)
  );

  logic [31:0] bram    [4096];
  logic [31:0] ref_mem [4096];

  // BRAM model: read-first, byte-enabled write, 1-cycle read latency.
  always @(posedge clk_g) begin
    if (bus.bb_ena_c) begin
      bus.bb_douta_g <= bram[bus.bb_addra_c];
      for (int b = 0; b < 4; b++)
        if (bus.bb_wea_c[b]) bram[bus.bb_addra_c][b*8 +: 8] <= bus.bb_dina_c[b*8 +: 8];
    end
  end

  typedef struct {
    int          owner;  // 0 none, 1 fetch, 2 loader
    logic        hata;
    logic [31:0] veri;
  } exp_t;
  exp_t q[$];

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_1000) && (a < 32'h0000_5000);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_gt_hazir"}, 32'(bus.gt_hazir_c), 32'(0));
    check({tag, "_yk_hazir"}, 32'(bus.yk_hazir_c), 32'(0));
    check({tag, "_gt_vld"},   32'(bus.gt_yanit_gecerli_c), 32'(0));
    check({tag, "_gt_veri"},  bus.gt_yanit_veri_c, 32'h0);
    check({tag, "_gt_hata"},  32'(bus.gt_yanit_hata_c), 32'(0));
    check({tag, "_yk_vld"},   32'(bus.yk_yanit_gecerli_c), 32'(0));
    check({tag, "_yk_veri"},  bus.yk_yanit_veri_c, 32'h0);
    check({tag, "_yk_hata"},  32'(bus.yk_yanit_hata_c), 32'(0));
    check({tag, "_ena"},      32'(bus.bb_ena_c), 32'(0));
    check({tag, "_wea"},      32'(bus.bb_wea_c), 32'(0));
  endtask

  // One cycle: drive inputs, check the previous grant's response and this cycle's
  // grant/BRAM outputs, then queue the response expected next cycle.
  task automatic step(input int grant, input logic gi, input logic [31:0] ga,
                      input logic yi, input logic yw, input logic yl,
                      input logic [31:0] ya, input logic [31:0] yd,
                      input logic [3:0] ym, input logic ip);
    exp_t        p, e;
    logic        gv, yv, lg, wr;
    logic [31:0] a;
    logic [11:0] w;
    bus.gt_istek_g = gi;  bus.gt_adres_g = ga;  bus.gt_iptal_g = ip;
    bus.yk_istek_g = yi;  bus.yk_yaz_g = yw;    bus.yk_kilit_g = yl;
    bus.yk_adres_g = ya;  bus.yk_veri_g = yd;   bus.yk_maske_g = ym;
    @(negedge clk_g);
    if (q.size() == 0) p = '{0, 1'b0, 32'h0};
    else               p = q.pop_front();
    gv = (p.owner == 1) && !ip;
    yv = (p.owner == 2);
    check("gt_vld",  32'(bus.gt_yanit_gecerli_c), 32'(gv));
    check("gt_veri", bus.gt_yanit_veri_c, gv ? p.veri : 32'h0);
    check("gt_hata", 32'(bus.gt_yanit_hata_c), 32'(gv && p.hata));
    check("yk_vld",  32'(bus.yk_yanit_gecerli_c), 32'(yv));
    check("yk_veri", bus.yk_yanit_veri_c, yv ? p.veri : 32'h0);
    check("yk_hata", 32'(bus.yk_yanit_hata_c), 32'(yv && p.hata));
    check("gt_hazir", 32'(bus.gt_hazir_c), 32'(grant == 1));
    check("yk_hazir", 32'(bus.yk_hazir_c), 32'(grant == 2));
    a  = (grant == 2) ? ya : ga;
    wr = (grant == 2) && yw;
    lg = (grant != 0) && legal(a);
    w  = 12'((a - 32'h0000_1000) >> 2);
    check("ena",  32'(bus.bb_ena_c), 32'(lg));
    check("wea",  32'(bus.bb_wea_c), 32'((lg && wr) ? ym : 4'b0000));
    check("dina", bus.bb_dina_c, (lg && wr) ? yd : 32'h0);
    if (lg) check("addra", 32'(bus.bb_addra_c), 32'(w));
    e.owner = grant;
    e.hata  = !lg;
    e.veri  = (lg && !wr) ? ref_mem[w] : 32'h0;
    if (lg && wr)
      for (int b = 0; b < 4; b++) if (ym[b]) ref_mem[w][b*8 +: 8] = yd[b*8 +: 8];
    q.push_back(e);
    @(posedge clk_g);
    #1;
  endtask

  task automatic idle(input logic ip);
    step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ip);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 4096; i++) begin
      bram[i]    = init_val(i);
      ref_mem[i] = init_val(i);
    end
    rst_g = 1'b1;
    bus.gt_istek_g = 1'b0; bus.gt_adres_g = 32'h0; bus.gt_iptal_g = 1'b0;
    bus.yk_istek_g = 1'b0; bus.yk_yaz_g = 1'b0; bus.yk_kilit_g = 1'b0;
    bus.yk_adres_g = 32'h0; bus.yk_veri_g = 32'h0; bus.yk_maske_g = 4'h0;
    repeat (2) @(posedge clk_g);
    @(negedge clk_g);
    check_zero("reset");
    @(posedge clk_g); #1;
    rst_g = 1'b0;

    // Both requesting, no lock: fetch wins first, then strict alternation.
    for (int i = 0; i < 6; i++)
      step((i % 2 == 0) ? 1 : 2, 1'b1, 32'h1100 + 32'(4*i), 1'b1, 1'b0, 1'b0,
           32'h1200 + 32'(4*i), 32'h0, 4'h0, 1'b0);

    // Fetch-only stream.
    for (int i = 0; i < 3; i++)
      step(1, 1'b1, 32'h1000 + 32'(4*i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Masked loader write then readback.
    step(2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1010, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    step(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1010, 32'h0, 4'h0, 1'b0);
    idle(1'b0);
    v = init_val(4);
    check("bram_lo", {16'h0, bram[4][15:0]}, 32'h0000_BEEF);
    check("bram_hi", {16'h0, bram[4][31:16]}, {16'h0, v[31:16]});

    // Illegal and boundary addresses.
    step(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1002, 32'h0, 4'h0, 1'b0);
    step(1, 1'b1, 32'h0FFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h5000, 32'h0, 4'h0, 1'b0);
    step(2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h5000, 32'h1234_5678, 4'hF, 1'b0);
    step(1, 1'b1, 32'h4FFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(1, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle(1'b0);

    // Redirect drops the fetch response only; loader response is untouched.
    step(1, 1'b1, 32'h1020, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1024, 32'h0, 4'h0, 1'b1);
    idle(1'b1);

    // Lock: entry, 64 locked grants with fetch waiting, forced fetch, re-lock, release.
    step(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 64; i++)
      step(2, 1'b1, 32'h1040, 1'b1, 1'b0, 1'b1, 32'h1000 + 32'(4*(i % 8)), 32'h0, 4'h0, 1'b0);
    step(1, 1'b1, 32'h1040, 1'b1, 1'b0, 1'b1, 32'h1008, 32'h0, 4'h0, 1'b0);
    step(2, 1'b1, 32'h1044, 1'b1, 1'b0, 1'b1, 32'h100C, 32'h0, 4'h0, 1'b0);
    step(2, 1'b1, 32'h1044, 1'b1, 1'b0, 1'b1, 32'h1014, 32'h0, 4'h0, 1'b0);
    step(2, 1'b1, 32'h1044, 1'b1, 1'b0, 1'b0, 32'h1018, 32'h0, 4'h0, 1'b0);
    step(1, 1'b1, 32'h1044, 1'b1, 1'b0, 1'b0, 32'h101C, 32'h0, 4'h0, 1'b0);
    idle(1'b0);

    // Reset the cycle after a grant; a loader write presented during reset must not land.
    step(1, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    rst_g = 1'b1;
    bus.gt_istek_g = 1'b1; bus.gt_adres_g = 32'h1004;
    bus.yk_istek_g = 1'b1; bus.yk_yaz_g = 1'b1; bus.yk_adres_g = 32'h1000;
    bus.yk_veri_g = 32'hFFFF_FFFF; bus.yk_maske_g = 4'hF;
    @(negedge clk_g);
    check_zero("rst_mid");
    q.delete();
    @(posedge clk_g); #1;
    rst_g = 1'b0;
    idle(1'b0);
    check("rst_nowrite", bram[0], ref_mem[0]);

    // After reset, the first conflict goes to fetch again.
    step(1, 1'b1, 32'h1030, 1'b1, 1'b0, 1'b0, 32'h1034, 32'h0, 4'h0, 1'b0);
    step(2, 1'b1, 32'h1030, 1'b1, 1'b0, 1'b0, 32'h1034, 32'h0, 4'h0, 1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
